fb_loader: RTL
==============

FB_LOADER -- requirements
Module: fb_loader

Interface
REQ-001 Parameter FILL_BYTE, default 8'h00, byte written to every word during a clear.
REQ-002 Parameter MSB_FIRST, default 1: 1 means byte bit 7 is the leftmost pixel of its 8-pixel group; 0 means bit 0 is leftmost.
REQ-003 clk25M  input  1  single pixel clock; all logic is on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  8  packed pixel byte, 8 horizontally adjacent 1-bit pixels.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  loader accepts in_data this cycle.
REQ-008 sof  input  1  one-cycle start-of-frame pulse; starts or restarts a load at word 0.
REQ-009 clr_req  input  1  one-cycle request to fill the whole buffer with FILL_BYTE.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 done  output  1  one-cycle pulse when a load or clear completes.
REQ-012 rd_addr  input  16  display pixel address, {y[7:0], x[7:0]}.
REQ-013 rgb  output  1  pixel value at rd_addr, one cycle late.

Function
REQ-014 Storage SHALL be 8192 x 8-bit words, 256x256 1-bit pixels; word index = pixel address [15:3]; memory contents are not reset.
REQ-015 States SHALL be IDLE, LOAD and CLEAR, with a 13-bit write pointer wr_ptr.
REQ-016 IDLE: clr_req -> CLEAR with wr_ptr=0; otherwise sof -> LOAD with wr_ptr=0; clr_req wins when both are high.
REQ-017 in_ready SHALL equal (state==LOAD) && !sof && !clr_req, and is combinational.
REQ-018 LOAD: each cycle with in_valid && in_ready writes in_data to mem[wr_ptr] and increments wr_ptr; in_valid alone never changes state.
REQ-019 LOAD: the beat accepted at wr_ptr==8191 SHALL pulse done on the next cycle and return to IDLE; wr_ptr wraps to 0.
REQ-020 LOAD + sof (no clr_req): no write that cycle; wr_ptr <= 0; stay in LOAD; no done pulse.
REQ-021 LOAD + clr_req: abort the load, no write that cycle, wr_ptr <= 0, go to CLEAR; no done pulse for the aborted load.
REQ-022 CLEAR: write FILL_BYTE to mem[wr_ptr] every cycle for 8192 consecutive cycles (0..8191), then pulse done and go to IDLE; sof and clr_req are ignored in CLEAR.
REQ-023 done SHALL be registered and high for exactly one cycle, coincident with the first IDLE cycle.
REQ-024 Read path: a registered word read of mem[rd_addr[15:3]] plus a registered copy of rd_addr[2:0]; rgb = selected bit of that word.
REQ-025 Bit select: index 7-rd_addr[2:0] when MSB_FIRST=1, else rd_addr[2:0].
REQ-026 Latency rd_addr -> rgb SHALL be exactly 1 clock, with one read every cycle and no stalls.
REQ-027 Read and write to the same word in the same cycle SHALL return the old word (read-first).
REQ-028 The read path SHALL run independently of the state machine and stay valid during LOAD and CLEAR.

Reset
REQ-029 reset_n low SHALL force, asynchronously: state=IDLE, wr_ptr=0, done=0, busy=0, in_ready=0, the read word register=0, the bit index register=0, and therefore rgb=0.
REQ-030 Reset during LOAD or CLEAR SHALL abandon the operation with no done pulse; words already written keep their values.
REQ-031 After reset release, the first sof or clr_req SHALL be honoured on the first active clock edge.

Verification
REQ-032 Reset then clr_req with FILL_BYTE=8'h00 -> busy high for 8192 cycles, one done pulse, then rgb=0 for every rd_addr.
REQ-033 sof then 8192 beats of 8'hA5 with in_valid held high -> done exactly one cycle after the last beat; with MSB_FIRST=1, rd_addr 0..7 gives rgb 1,0,1,0,0,1,0,1 one cycle after each address.
REQ-034 Load with in_valid toggling randomly -> only handshaked beats are written, in order; the final memory image matches the source bytes.
REQ-035 sof at beat 100 of a load, then 8192 beats of 8'hFF -> no done at beat 100; exactly one done at the end; all pixels read 1.
REQ-036 clr_req at beat 50 of a load -> in_ready drops in that same cycle and CLEAR runs 8192 cycles; sof during CLEAR is ignored; one done pulse at the end.
REQ-037 reset_n pulsed low mid-CLEAR -> all outputs 0 immediately; no done pulse; a new sof is accepted on the first edge after release.

Source files
------------

// File: rtl/fb_loader.sv
// fb_loader: 256x256 1-bit frame buffer with a streaming byte loader and a bulk clear.
// The write side is driven by a small IDLE/LOAD/CLEAR state machine. The display read
// path runs every cycle, independent of that state machine, with one clock of latency.
module fb_loader #(
    parameter logic [7:0] FILL_BYTE = 8'h00,
    parameter bit         MSB_FIRST = 1'b1
) (
    input  logic        clk25M,
    input  logic        reset_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sof,
    input  logic        clr_req,
    output logic        busy,
    output logic        done,
    input  logic [15:0] rd_addr,
    output logic        rgb
);

    localparam int unsigned Words = 8192;
    localparam int unsigned PtrW  = 13;

    localparam logic [PtrW-1:0] PtrLast = 13'h1FFF;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StClear
    } state_e;

    state_e          state_q, state_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic            done_q, done_d;

    logic            mem_we;
    logic [7:0]      mem_wdata;

    // Frame storage. Contents are deliberately not reset.
    logic [7:0]      mem [Words];

    logic [7:0]      rd_word_q;
    logic [2:0]      rd_bit_q;
    logic [2:0]      bit_idx;

    // A beat is only accepted in LOAD when no restart or clear is requested.
    // A pending sof or clr_req masks the handshake in the same cycle.
    assign in_ready = (state_q == StLoad) && !sof && !clr_req;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;

    // Next state, write pointer, write enable and completion pulse.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = in_data;

        case (state_q)
            StIdle: begin
                // A clear takes priority over a load.
                if (clr_req) begin
                    state_d  = StClear;
                    wr_ptr_d = '0;
                end else if (sof) begin
                    state_d  = StLoad;
                    wr_ptr_d = '0;
                end
            end

            StLoad: begin
                if (clr_req) begin
                    // Abort the load. Nothing is written and no done is pulsed.
                    state_d  = StClear;
                    wr_ptr_d = '0;
                end else if (sof) begin
                    // Restart the frame from word 0 without leaving LOAD.
                    wr_ptr_d = '0;
                end else if (in_valid) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == PtrLast) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end

            StClear: begin
                // CLEAR runs to completion. sof and clr_req are ignored here.
                mem_we    = 1'b1;
                mem_wdata = FILL_BYTE;
                wr_ptr_d  = wr_ptr_q + 1'b1;
                if (wr_ptr_q == PtrLast) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d  = StIdle;
                wr_ptr_d = '0;
            end
        endcase
    end

    // Control state register. Reset abandons any operation in flight.
    always_ff @(posedge clk25M or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            done_q   <= done_d;
        end
    end

    // Memory write port. There is no reset, so written words survive a reset.
    always_ff @(posedge clk25M) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= mem_wdata;
        end
    end

    // Registered read of the addressed word plus its pixel offset. A non-blocking read
    // returns the old word when the same word is written in the same cycle.
    always_ff @(posedge clk25M or negedge reset_n) begin
        if (!reset_n) begin
            rd_word_q <= '0;
            rd_bit_q  <= '0;
        end else begin
            rd_word_q <= mem[rd_addr[15:3]];
            rd_bit_q  <= rd_addr[2:0];
        end
    end

    // For MSB-first packing, 7 - x equals ~x on three bits.
    assign bit_idx = MSB_FIRST ? ~rd_bit_q : rd_bit_q;
    assign rgb     = rd_word_q[bit_idx];

endmodule
